// File: rtl/ps2_scan_parser_pkg.sv
// Shared definitions for the PS/2 scan-code parser: special byte values,
// parser states and the packed key-event layout {ext, brk, code}.
package ps2_scan_parser_pkg;

  localparam logic [7:0] SC_EXT  = 8'hE0;
  localparam logic [7:0] SC_BRK  = 8'hF0;
  localparam logic [7:0] SC_ERR0 = 8'h00;
  localparam logic [7:0] SC_ERR1 = 8'hFF;

  localparam int EV_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PFX_E0   = 2'd1,
    ST_PFX_F0   = 2'd2,
    ST_PFX_E0F0 = 2'd3
  } parse_state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } kb_event_t;

  function automatic logic is_err_byte(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/kb_event_fifo.sv
// First-word-fall-through FIFO holding parsed key events.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module kb_event_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_scan_parser.sv
// Folds raw PS/2 scan bytes (E0/F0 prefixes + code) into key events,
// filters typematic repeats and queues events behind a valid/ready port.
module ps2_scan_parser
  import ps2_scan_parser_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int TIMEOUT_CYC   = 2500000,
  parameter int FILTER_REPEAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scan_done_tick,
  input  logic [7:0] scan_out,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_brk,
  output logic       got_code_tick,
  output logic       overflow
);

  localparam int TW = $clog2(TIMEOUT_CYC);

  parse_state_t state, state_next;
  logic [TW-1:0] to_cnt;
  logic          timeout_hit;
  logic          emit;
  kb_event_t     new_ev;
  kb_event_t     head_ev;
  logic          held_valid;
  logic          held_ext;
  logic [7:0]    held_code;
  logic          held_match;
  logic          push;
  logic          fifo_empty;
  logic          fifo_full;

  assign timeout_hit = (state != ST_IDLE) && !scan_done_tick &&
                       (to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      to_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == ST_IDLE || scan_done_tick || timeout_hit) to_cnt <= '0;
      else                                                   to_cnt <= to_cnt + 1'b1;
    end
  end

  // E0 always lands in PFX_E0; F0 lands in PFX_E0F0 only after a bare E0.
  always_comb begin
    state_next  = state;
    emit        = 1'b0;
    new_ev.ext  = (state == ST_PFX_E0) || (state == ST_PFX_E0F0);
    new_ev.brk  = (state == ST_PFX_F0) || (state == ST_PFX_E0F0);
    new_ev.code = scan_out;
    if (scan_done_tick) begin
      if (is_err_byte(scan_out)) begin
        state_next = ST_IDLE;
      end else if (scan_out == SC_EXT) begin
        state_next = ST_PFX_E0;
      end else if (scan_out == SC_BRK) begin
        state_next = (state == ST_PFX_E0) ? ST_PFX_E0F0 : ST_PFX_F0;
      end else begin
        state_next = ST_IDLE;
        emit       = 1'b1;
      end
    end else if (timeout_hit) begin
      state_next = ST_IDLE;
    end
  end

  assign held_match = held_valid && (held_ext == new_ev.ext) && (held_code == new_ev.code);
  assign push       = emit && !((FILTER_REPEAT != 0) && !new_ev.brk && held_match);

  // Held key tracks the last make, even if that make was dropped by overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_valid    <= 1'b0;
      held_ext      <= 1'b0;
      held_code     <= '0;
      got_code_tick <= 1'b0;
      overflow      <= 1'b0;
    end else begin
      got_code_tick <= push && new_ev.brk;
      if (push && fifo_full && !ev_ready) overflow <= 1'b1;
      if (push && !new_ev.brk) begin
        held_valid <= 1'b1;
        held_ext   <= new_ev.ext;
        held_code  <= new_ev.code;
      end else if (push && new_ev.brk && held_match) begin
        held_valid <= 1'b0;
      end
    end
  end

  kb_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (new_ev),
    .pop   (ev_ready),
    .dout  (head_ev),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign ev_valid = !fifo_empty;
  assign ev_code  = ev_valid ? head_ev.code : 8'h00;
  assign ev_ext   = ev_valid && head_ev.ext;
  assign ev_brk   = ev_valid && head_ev.brk;

endmodule

// File: tb/tb_ps2_scan_parser.sv
// Directed self-checking bench for ps2_scan_parser with a 4-deep FIFO
// and a short prefix timeout so the timeout path is reachable quickly.
module tb_ps2_scan_parser;

  localparam int TIMEOUT = 16;

  logic       clk;
  logic       reset;
  logic       scan_done_tick;
  logic [7:0] scan_out;
  logic       ev_ready;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_brk;
  logic       got_code_tick;
  logic       overflow;

  int test_count = 0;
  int fail_count = 0;

  ps2_scan_parser #(
    .FIFO_DEPTH    (4),
    .TIMEOUT_CYC   (TIMEOUT),
    .FILTER_REPEAT (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .scan_done_tick (scan_done_tick),
    .scan_out       (scan_out),
    .ev_ready       (ev_ready),
    .ev_valid       (ev_valid),
    .ev_code        (ev_code),
    .ev_ext         (ev_ext),
    .ev_brk         (ev_brk),
    .got_code_tick  (got_code_tick),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ev_word(input bit v, input bit e, input bit b,
                                          input logic [7:0] c);
    return {21'd0, v, e, b, c};
  endfunction

  function automatic logic [31:0] head_word();
    return {21'd0, ev_valid, ev_ext, ev_brk, ev_code};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // One byte strobe; returns 1 ns after the edge that writes any resulting event.
  task automatic applyStimulus(input logic [7:0] b);
    @(posedge clk); #1;
    scan_done_tick = 1'b1;
    scan_out       = b;
    @(posedge clk); #1;
    scan_done_tick = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic popOne();
    @(posedge clk); #1;
    ev_ready = 1'b1;
    @(posedge clk); #1;
    ev_ready = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    scan_done_tick = 1'b0;
    scan_out       = 8'h00;
    ev_ready       = 1'b0;
    idleCycles(2);
    checkOutput("reset_ev", head_word(), 32'd0);
    checkOutput("reset_got", {31'd0, got_code_tick}, 32'd0);
    checkOutput("reset_ovf", {31'd0, overflow}, 32'd0);
    reset = 1'b1;
    idleCycles(1);

    // Make then break with the consumer always ready
    ev_ready = 1'b1;
    applyStimulus(8'h1C);
    checkOutput("t1_make", head_word(), ev_word(1, 0, 0, 8'h1C));
    checkOutput("t1_make_got", {31'd0, got_code_tick}, 32'd0);
    applyStimulus(8'hF0);
    checkOutput("t1_prefix_noev", head_word(), 32'd0);
    applyStimulus(8'h1C);
    checkOutput("t1_break", head_word(), ev_word(1, 0, 1, 8'h1C));
    checkOutput("t1_break_got", {31'd0, got_code_tick}, 32'd1);
    idleCycles(1);
    checkOutput("t1_got_pulse", {31'd0, got_code_tick}, 32'd0);
    checkOutput("t1_drained", head_word(), 32'd0);

    // Extended make and break
    applyStimulus(8'hE0);
    applyStimulus(8'h75);
    checkOutput("t2_ext_make", head_word(), ev_word(1, 1, 0, 8'h75));
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h75);
    checkOutput("t2_ext_break", head_word(), ev_word(1, 1, 1, 8'h75));
    checkOutput("t2_ext_got", {31'd0, got_code_tick}, 32'd1);
    idleCycles(1);
    ev_ready = 1'b0;

    // Typematic repeats of a held key collapse to one make
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h1C);
      checkOutput("t3_repeat_head", head_word(), ev_word(1, 0, 0, 8'h1C));
    end
    applyStimulus(8'hF0);
    applyStimulus(8'h1C);
    checkOutput("t3_break_got", {31'd0, got_code_tick}, 32'd1);
    checkOutput("t3_head0", head_word(), ev_word(1, 0, 0, 8'h1C));
    popOne();
    checkOutput("t3_head1", head_word(), ev_word(1, 0, 1, 8'h1C));
    popOne();
    checkOutput("t3_empty", head_word(), 32'd0);

    // Overflow with the consumer stalled, then push+pop while full
    applyStimulus(8'h11);
    applyStimulus(8'h12);
    applyStimulus(8'h13);
    applyStimulus(8'h14);
    checkOutput("t4_full_no_ovf", {31'd0, overflow}, 32'd0);
    applyStimulus(8'h15);
    checkOutput("t4_ovf", {31'd0, overflow}, 32'd1);
    @(posedge clk); #1;
    ev_ready       = 1'b1;
    scan_done_tick = 1'b1;
    scan_out       = 8'h16;
    @(posedge clk); #1;
    ev_ready       = 1'b0;
    scan_done_tick = 1'b0;
    checkOutput("t4_head_12", head_word(), ev_word(1, 0, 0, 8'h12));
    popOne();
    checkOutput("t4_head_13", head_word(), ev_word(1, 0, 0, 8'h13));
    popOne();
    checkOutput("t4_head_14", head_word(), ev_word(1, 0, 0, 8'h14));
    popOne();
    checkOutput("t4_head_16", head_word(), ev_word(1, 0, 0, 8'h16));
    popOne();
    checkOutput("t4_empty", head_word(), 32'd0);
    checkOutput("t4_ovf_sticky", {31'd0, overflow}, 32'd1);

    // Error bytes abort a pending prefix
    applyStimulus(8'hE0);
    applyStimulus(8'hFF);
    checkOutput("err_ff_noev", head_word(), 32'd0);
    applyStimulus(8'h75);
    checkOutput("err_ff_plain", head_word(), ev_word(1, 0, 0, 8'h75));
    popOne();
    applyStimulus(8'hE0);
    applyStimulus(8'hF0);
    applyStimulus(8'h00);
    applyStimulus(8'h1C);
    checkOutput("err_00_plain", head_word(), ev_word(1, 0, 0, 8'h1C));
    popOne();

    // Prefix timeout: a long gap discards E0, a short gap keeps it
    applyStimulus(8'hE0);
    idleCycles(TIMEOUT);
    applyStimulus(8'h2A);
    checkOutput("t5_timeout", head_word(), ev_word(1, 0, 0, 8'h2A));
    popOne();
    applyStimulus(8'hE0);
    idleCycles(TIMEOUT - 4);
    applyStimulus(8'h2B);
    checkOutput("t5_no_timeout", head_word(), ev_word(1, 1, 0, 8'h2B));
    popOne();

    // Reset in the middle of a break sequence
    applyStimulus(8'h33);
    applyStimulus(8'hF0);
    @(posedge clk); #1;
    reset = 1'b0;
    #2;
    checkOutput("t6_rst_ev", head_word(), 32'd0);
    checkOutput("t6_rst_ovf", {31'd0, overflow}, 32'd0);
    checkOutput("t6_rst_got", {31'd0, got_code_tick}, 32'd0);
    idleCycles(2);
    reset = 1'b1;
    applyStimulus(8'h1C);
    checkOutput("t6_after_rst", head_word(), ev_word(1, 0, 0, 8'h1C));
    checkOutput("t6_after_got", {31'd0, got_code_tick}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
